// File: rtl/zxuno_uart_bridge_pkg.sv
// ---------------------------------------------------------------------------
// zxuno_uart_bridge_pkg
//   Shared constants and types for the serial-to-register-bus bridge:
//   command opcodes, reply codes, command FSM and receiver FSM encodings.
// ---------------------------------------------------------------------------
package zxuno_uart_bridge_pkg;

    localparam logic [7:0] OP_WR = 8'h57;  // 'W' addr data
    localparam logic [7:0] OP_RD = 8'h52;  // 'R' addr
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_SEND,       // hand reply byte to the serialiser
        ST_SEND_WAIT   // wait for its stop bit to finish
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // States in which the host must hold off sending.
    function automatic logic holds_off(input state_t s);
        return (s == ST_BUS_WR) || (s == ST_BUS_RD) ||
               (s == ST_SEND)   || (s == ST_SEND_WAIT);
    endfunction

endpackage

// File: rtl/zxuno_uart_bridge_phy.sv
// ---------------------------------------------------------------------------
// bridge_uart_phy
//   8N1 serial PHY: 2-flop rx synchroniser + deserialiser, tx serialiser.
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     uart_rx          serial in (asynchronous, idle high)
//     uart_tx          serial out (idle high)
//     rx_byte          last received byte, valid with byte_valid
//     byte_valid       one-clock pulse per correctly framed byte
//     tx_start/tx_data start a transmit; accepted only while tx_busy=0
//     tx_busy          high from accepted tx_start to end of stop bit
// ---------------------------------------------------------------------------
module bridge_uart_phy #(
    parameter int DIV = 243
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy
);
    import zxuno_uart_bridge_pkg::*;

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    // ---------------- receiver ----------------
    logic            rx_s1, rx_s2, rx_s3;
    rx_state_t       rx_q, rx_d;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_fall, rx_half, rx_full;

    assign rx_fall = rx_s3 & ~rx_s2;
    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_full = (rx_cnt == DIV_LAST);
    assign rx_byte = rx_shift;

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_d = rx_q;
        unique case (rx_q)
            RX_IDLE:  if (rx_fall) rx_d = RX_START;
            // Line back high at mid start bit means it was a glitch.
            RX_START: if (rx_half) rx_d = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_d = RX_STOP;
            RX_STOP:  if (rx_full) rx_d = RX_IDLE;
            default:  rx_d = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_q       <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            rx_q       <= rx_d;
            // Stop bit sampled low is a framing error: no pulse.
            byte_valid <= (rx_q == RX_STOP) && rx_full && rx_s2;
            if (rx_q == RX_IDLE || rx_d != rx_q || rx_full)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_q == RX_START) begin
                rx_bit <= '0;
            end else if (rx_q == RX_DATA && rx_full) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // ---------------- transmitter ----------------
    logic          tx_active;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;

    assign uart_tx = tx_active ? tx_shift[0] : 1'b1;
    assign tx_busy = tx_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (!tx_active) begin
            if (tx_start) begin
                tx_active <= 1'b1;
                tx_shift  <= {1'b1, tx_data, 1'b0};
                tx_bit    <= '0;
                tx_cnt    <= '0;
            end
        end else if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_active <= 1'b0;
            end else begin
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/zxuno_uart_bridge.sv
// ---------------------------------------------------------------------------
// zxuno_uart_bridge
//   Serial command bridge acting as a second ZX-UNO register-bus master.
//   'W' addr data -> register write, reply ACK; 'R' addr -> register read,
//   reply data byte; other opcodes -> NAK.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     uart_rx / uart_tx   8N1 serial link to host
//     uart_rts            0 = ready for bytes, 1 = hold off
//     zxuno_addr, dout    register address / write data
//     zxuno_regwr         one-clock write strobe
//     zxuno_regrd         read strobe, RD_CYCLES clocks
//     din, oe_n           read data and its "driven" flag (active low)
//     busy                command in progress (opcode to reply stop bit)
// ---------------------------------------------------------------------------
module zxuno_uart_bridge #(
    parameter int CLK_HZ         = 28000000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 2800000,
    parameter int RD_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       uart_rts,
    output logic [7:0] zxuno_addr,
    output logic       zxuno_regwr,
    output logic       zxuno_regrd,
    output logic [7:0] dout,
    input  logic [7:0] din,
    input  logic       oe_n,
    output logic       busy
);
    import zxuno_uart_bridge_pkg::*;

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int BW  = $clog2(RD_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] RD_LAST = BW'(RD_CYCLES);

    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    reply;

    state_t        state_q, state_d;
    logic          is_wr;
    logic          rts_hold;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] bus_cnt;
    logic          in_get;
    logic          to_expired;

    bridge_uart_phy #(.DIV(DIV)) u_phy (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .tx_start   (tx_start),
        .tx_data    (reply),
        .tx_busy    (tx_busy)
    );

    assign in_get      = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign to_expired  = in_get && (to_cnt == TO_LAST);
    assign busy        = (state_q != ST_IDLE);
    assign uart_rts    = rts_hold | holds_off(state_q);
    assign zxuno_regwr = (state_q == ST_BUS_WR);
    // First BUS_RD cycle is address setup; strobe covers the next RD_CYCLES.
    assign zxuno_regrd = (state_q == ST_BUS_RD) && (bus_cnt != '0);

    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        unique case (state_q)
            ST_IDLE:
                if (byte_valid)
                    state_d = (rx_byte == OP_WR || rx_byte == OP_RD) ? ST_GET_ADDR : ST_SEND;
            ST_GET_ADDR:
                if (byte_valid)      state_d = is_wr ? ST_GET_DATA : ST_BUS_RD;
                else if (to_expired) state_d = ST_IDLE;
            ST_GET_DATA:
                if (byte_valid)      state_d = ST_BUS_WR;
                else if (to_expired) state_d = ST_IDLE;
            ST_BUS_WR:
                state_d = ST_SEND;
            ST_BUS_RD:
                if (bus_cnt == RD_LAST) state_d = ST_SEND;
            ST_SEND:
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = ST_SEND_WAIT;
                end
            ST_SEND_WAIT:
                if (!tx_busy) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // NOTE: bus outputs and command registers are reset because they are
    // visible on the register bus; leaving them X would leak onto it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rts_hold   <= 1'b1;
            is_wr      <= 1'b0;
            reply      <= '0;
            zxuno_addr <= '0;
            dout       <= '0;
            to_cnt     <= '0;
            bus_cnt    <= '0;
        end else begin
            state_q  <= state_d;
            rts_hold <= 1'b0;

            if (byte_valid || !in_get) to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;

            if (state_q == ST_BUS_RD) bus_cnt <= bus_cnt + 1'b1;
            else                      bus_cnt <= '0;

            unique case (state_q)
                ST_IDLE:
                    if (byte_valid) begin
                        is_wr <= (rx_byte == OP_WR);
                        reply <= NAK;
                    end
                ST_GET_ADDR: if (byte_valid) zxuno_addr <= rx_byte;
                ST_GET_DATA: if (byte_valid) dout <= rx_byte;
                ST_BUS_WR:   reply <= ACK;
                ST_BUS_RD:
                    if (bus_cnt == RD_LAST) reply <= oe_n ? 8'hFF : din;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zxuno_uart_bridge.sv
`timescale 1ns/1ps
module tb_zxuno_uart_bridge;

    localparam int CLK_HZ = 28000000;
    localparam int BAUD   = 115200;
    localparam int DIV    = CLK_HZ / BAUD;   // 243
    localparam int TO_CYC = 3000;            // scaled-down inter-byte timeout
    localparam int RD_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx, uart_rts, zxuno_regwr, zxuno_regrd, busy;
    logic [7:0] zxuno_addr, dout, din;
    logic       oe_n;

    always #5 clk = ~clk;

    zxuno_uart_bridge #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYCLES(TO_CYC), .RD_CYCLES(RD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .uart_rts(uart_rts), .zxuno_addr(zxuno_addr), .zxuno_regwr(zxuno_regwr),
        .zxuno_regrd(zxuno_regrd), .dout(dout), .din(din), .oe_n(oe_n), .busy(busy)
    );

    // Peripheral model: only address C7 answers, with C0.
    always_comb begin
        oe_n = 1'b1;
        din  = 8'h00;
        if (zxuno_regrd && zxuno_addr == 8'hC7) begin
            oe_n = 1'b0;
            din  = 8'hC0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor
    int         wr_cnt = 0, rd_cyc = 0, overlap = 0, addr_err = 0;
    logic [7:0] wr_addr, wr_data, rd_addr, prev_addr;
    logic       prev_rd = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (zxuno_regwr) begin wr_cnt++; wr_addr = zxuno_addr; wr_data = dout; end
            if (zxuno_regrd) begin rd_cyc++; rd_addr = zxuno_addr; end
            if (zxuno_regwr && zxuno_regrd) overlap++;
            if ((zxuno_regwr || (zxuno_regrd && !prev_rd)) && zxuno_addr !== prev_addr)
                addr_err++;
        end
        prev_addr = zxuno_addr;
        prev_rd   = zxuno_regrd;
    end

    // Serial receiver for replies
    logic [7:0] rq[$];
    logic       rts_at_tx, busy_at_tx;
    int         tx_frame_err = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            rts_at_tx  = uart_rts;
            busy_at_tx = busy;
            repeat (DIV / 2) @(negedge clk);
            if (uart_tx !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (DIV) @(negedge clk);
            if (uart_tx !== 1'b1) tx_frame_err++;
            rq.push_back(b);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_reply(input string tag, input logic [7:0] exp);
        int n = 0;
        while (rq.size() == 0 && n < 14 * DIV) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_present"}, 32'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
            check(tag, rq.pop_front(), exp);
            check({tag, "_rts"}, rts_at_tx, 1);
            check({tag, "_busy"}, busy_at_tx, 1);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int wb, rb;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", uart_tx, 1);
        check("rst_rts", uart_rts, 1);
        check("rst_busy", busy, 0);
        check("rst_addr", zxuno_addr, 8'h00);
        check("rst_dout", dout, 8'h00);
        check("rst_strobes", {zxuno_regwr, zxuno_regrd}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rts_after_release", uart_rts, 1);
        @(negedge clk);
        check("rts_ready", uart_rts, 0);

        // Write C6 <= 41
        wb = wr_cnt; rb = rd_cyc;
        send_byte(8'h57, 1'b1); send_byte(8'hC6, 1'b1); send_byte(8'h41, 1'b1);
        wait_reply("wr_ack", 8'h06);
        check("wr_count", wr_cnt - wb, 1);
        check("wr_addr", wr_addr, 8'hC6);
        check("wr_data", wr_data, 8'h41);
        check("wr_no_read", rd_cyc - rb, 0);
        repeat (DIV) @(negedge clk);
        check("busy_after_wr", busy, 0);

        // Read C7, peripheral answers C0
        wb = wr_cnt; rb = rd_cyc;
        send_byte(8'h52, 1'b1); send_byte(8'hC7, 1'b1);
        wait_reply("rd_c7", 8'hC0);
        check("rd_c7_cycles", rd_cyc - rb, RD_CYC);
        check("rd_c7_addr", rd_addr, 8'hC7);
        check("rd_c7_no_write", wr_cnt - wb, 0);
        repeat (DIV) @(negedge clk);

        // Read 10, nobody drives din
        rb = rd_cyc;
        send_byte(8'h52, 1'b1); send_byte(8'h10, 1'b1);
        wait_reply("rd_10", 8'hFF);
        check("rd_10_cycles", rd_cyc - rb, RD_CYC);
        check("rd_10_addr", rd_addr, 8'h10);
        repeat (DIV) @(negedge clk);

        // Framing error on opcode byte: ignored
        send_byte(8'h57, 1'b0);
        repeat (DIV) @(negedge clk);
        check("frame_err_busy", busy, 0);
        check("frame_err_no_reply", rq.size(), 0);

        // Unknown opcode -> NAK (also proves the bad 'W' was not taken)
        wb = wr_cnt; rb = rd_cyc;
        send_byte(8'h33, 1'b1);
        wait_reply("nak", 8'h15);
        check("nak_no_strobe", (wr_cnt - wb) + (rd_cyc - rb), 0);
        repeat (DIV) @(negedge clk);

        // Short glitch straddling a clock edge: no frame
        @(negedge clk);
        #4 uart_rx = 1'b0;
        #2 uart_rx = 1'b1;
        repeat (11 * DIV) @(negedge clk);
        check("glitch_busy", busy, 0);
        check("glitch_no_reply", rq.size(), 0);

        // Timeout between address and data, then a read
        wb = wr_cnt; rb = rd_cyc;
        send_byte(8'h57, 1'b1); send_byte(8'hC6, 1'b1);
        repeat (TO_CYC + 200) @(negedge clk);
        check("timeout_busy", busy, 0);
        send_byte(8'h52, 1'b1); send_byte(8'hC7, 1'b1);
        wait_reply("to_rd", 8'hC0);
        check("to_no_write", wr_cnt - wb, 0);
        check("to_rd_cycles", rd_cyc - rb, RD_CYC);
        repeat (DIV) @(negedge clk);
        check("to_single_reply", rq.size(), 0);

        // Reset in the middle of a reply
        send_byte(8'h57, 1'b1); send_byte(8'hC6, 1'b1); send_byte(8'h41, 1'b1);
        for (int i = 0; i < 4 * DIV && uart_tx === 1'b1; i++) @(negedge clk);
        check("reply_started", uart_tx, 0);
        repeat (4 * DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", uart_tx, 1);
        check("midrst_strobes", {zxuno_regwr, zxuno_regrd}, 2'b00);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7 * DIV) @(negedge clk);
        rq.delete();
        wb = wr_cnt;
        send_byte(8'h57, 1'b1); send_byte(8'hC6, 1'b1); send_byte(8'h41, 1'b1);
        wait_reply("post_rst_ack", 8'h06);
        check("post_rst_wr_count", wr_cnt - wb, 1);
        check("post_rst_wr_addr", wr_addr, 8'hC6);
        check("post_rst_wr_data", wr_data, 8'h41);

        // Global bus-protocol properties
        check("no_overlap", overlap, 0);
        check("addr_setup", addr_err, 0);
        check("tx_framing", tx_frame_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
